// File: rtl/io_fifo_port_pkg.sv
// Shared constants and helpers for the CPU-mapped TX/RX FIFO port.
package io_fifo_port_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ERR_W       = 2;
    localparam int unsigned CNT_FIELD_W = 4;

    // Register select taken from addr[3:2]
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_ERROR  = 2'd3
    } reg_sel_e;

    // STATUS bit positions
    localparam int unsigned ST_TX_EMPTY   = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_RX_EMPTY   = 2;
    localparam int unsigned ST_RX_FULL    = 3;
    localparam int unsigned ST_TX_CNT_LSB = 8;
    localparam int unsigned ST_RX_CNT_LSB = 16;

    // ERROR bit positions
    localparam int unsigned ERR_TX_OVF = 0;
    localparam int unsigned ERR_RX_UDF = 1;

    // CTRL flush bits
    localparam int unsigned CTRL_FLUSH_TX = 0;
    localparam int unsigned CTRL_FLUSH_RX = 1;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [DATA_W-1:0] pack_status(
        input logic                   tx_empty,
        input logic                   tx_full,
        input logic                   rx_empty,
        input logic                   rx_full,
        input logic [CNT_FIELD_W-1:0] tx_count,
        input logic [CNT_FIELD_W-1:0] rx_count
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_TX_FULL]  = tx_full;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_TX_CNT_LSB +: CNT_FIELD_W] = tx_count;
        s[ST_RX_CNT_LSB +: CNT_FIELD_W] = rx_count;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo_port_if.sv
// CPU bus plus TX/RX stream handshakes of the FIFO port.
interface io_fifo_port_if;
    import io_fifo_port_pkg::*;

    logic [DATA_W-1:0] addr;
    logic              cs;
    logic              wr_rd;
    logic [DATA_W-1:0] data_bus_write;
    logic [DATA_W-1:0] data_bus_read;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    // CPU / external side
    modport master (
        output addr, cs, wr_rd, data_bus_write, tx_ready, rx_data, rx_valid,
        input  data_bus_read, tx_data, tx_valid, rx_ready
    );

    // FIFO port side
    modport slave (
        input  addr, cs, wr_rd, data_bus_write, tx_ready, rx_data, rx_valid,
        output data_bus_read, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/io_fifo_port_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; fullness judged on the cycle-start count.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state: flush overrides, otherwise accepted push/pop move pointers and count
    always_comb begin
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; only valid entries are ever observed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_fifo_port.sv
// CPU-mapped port: DATA/STATUS/CTRL/ERROR registers over a TX and an RX FIFO.
module io_fifo_port
    import io_fifo_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    io_fifo_port_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    reg_sel_e          sel;
    logic              rd_access;
    logic              wr_access;
    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic [DATA_W-1:0] tx_rdata, rx_rdata;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ERR_W-1:0]  err_set, err_clr;
    logic [DATA_W-1:0] rd_data_c;
    logic              unused_addr;

    assign unused_addr = ^{bus.addr[DATA_W-1:4], bus.addr[1:0]};

    // Access decode, FIFO strobes and sticky error update
    always_comb begin
        rd_access = bus.cs && !bus.wr_rd;
        wr_access = bus.cs && bus.wr_rd;
        sel       = reg_sel_e'(bus.addr[3:2]);
        tx_push   = wr_access && (sel == REG_DATA);
        tx_flush  = wr_access && (sel == REG_CTRL) && bus.data_bus_write[CTRL_FLUSH_TX];
        rx_flush  = wr_access && (sel == REG_CTRL) && bus.data_bus_write[CTRL_FLUSH_RX];
        tx_pop    = bus.tx_ready && !tx_empty;
        rx_push   = bus.rx_valid && !rx_full;
        rx_pop    = rd_access && (sel == REG_DATA) && !rx_empty;
        err_set   = '0;
        err_set[ERR_TX_OVF] = tx_push && tx_full && !tx_flush;
        err_set[ERR_RX_UDF] = rd_access && (sel == REG_DATA) && rx_empty;
        err_clr   = '0;
        if (wr_access && (sel == REG_ERROR)) begin
            err_clr = bus.data_bus_write[ERR_W-1:0];
        end
        err_d     = (err_q & ~err_clr) | err_set;
    end

    // Sticky error bits; a set in the same cycle as a W1C clear survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    // CPU load data, combinational so it is ready in the access cycle
    always_comb begin
        rd_data_c = '0;
        if (rd_access) begin
            case (sel)
                REG_DATA:   rd_data_c = rx_empty ? '0 : rx_rdata;
                REG_STATUS: rd_data_c = pack_status(tx_empty, tx_full, rx_empty, rx_full,
                                                    CNT_FIELD_W'(tx_count),
                                                    CNT_FIELD_W'(rx_count));
                REG_ERROR:  rd_data_c = DATA_W'(err_q);
                default:    rd_data_c = '0;
            endcase
        end
    end

    assign bus.data_bus_read = rd_data_c;
    assign bus.tx_data       = tx_rdata;
    assign bus.tx_valid      = !tx_empty;
    assign bus.rx_ready      = !rx_full;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (bus.data_bus_write),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (bus.rx_data),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: tb/tb_io_fifo_port.sv
// Self-checking bench for io_fifo_port: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_io_fifo_port;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [1:0]  m_err;

    logic        tr;
    logic        rv;
    logic [31:0] rdat;
    logic [31:0] rd;

    io_fifo_port_if bus();

    io_fifo_port #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic c, input logic w, input logic [31:0] a);
        logic [31:0] s;
        s = 32'h0;
        if (c && !w) begin
            case (a[3:2])
                2'd0: s = (rxq.size() != 0) ? rxq[0] : 32'h0;
                2'd1: s = (32'(rxq.size()) << 16) | (32'(txq.size()) << 8)
                        | (32'(rxq.size() == DEPTH) << 3) | (32'(rxq.size() == 0) << 2)
                        | (32'(txq.size() == DEPTH) << 1) | 32'(txq.size() == 0);
                2'd3: s = {30'h0, m_err};
                default: s = 32'h0;
            endcase
        end
        return s;
    endfunction

    // Apply the effect of one clock edge to the reference model
    task automatic model_edge(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [1:0] sel;
        logic [1:0] set;
        logic [1:0] clr;
        bit tx_full0;
        bit rx_full0;
        bit tx_has0;
        bit rx_has0;
        sel = a[3:2];
        set = 2'b00;
        clr = 2'b00;
        tx_full0 = (txq.size() == DEPTH);
        rx_full0 = (rxq.size() == DEPTH);
        tx_has0  = (txq.size() != 0);
        rx_has0  = (rxq.size() != 0);
        if (c && w && sel == 2'd2 && d[0]) begin
            txq.delete();
        end else begin
            if (c && w && sel == 2'd0 && tx_full0) set[0] = 1'b1;
            if (tr && tx_has0) void'(txq.pop_front());
            if (c && w && sel == 2'd0 && !tx_full0) txq.push_back(d);
        end
        if (c && !w && sel == 2'd0 && !rx_has0) set[1] = 1'b1;
        if (c && w && sel == 2'd2 && d[1]) begin
            rxq.delete();
        end else begin
            if (c && !w && sel == 2'd0 && rx_has0) void'(rxq.pop_front());
            if (rv && !rx_full0) rxq.push_back(rdat);
        end
        if (c && w && sel == 2'd3) clr = d[1:0];
        m_err = (m_err & ~clr) | set;
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_err = 2'b00;
    endtask

    // Drive one cycle, check all outputs before the edge, advance the model
    task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdo);
        bus.cs = c;
        bus.wr_rd = w;
        bus.addr = a;
        bus.data_bus_write = d;
        bus.tx_ready = tr;
        bus.rx_valid = rv;
        bus.rx_data = rdat;
        #1;
        rdo = bus.data_bus_read;
        chk("bus_read", rdo, exp_read(c, w, a));
        chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", bus.tx_data, txq[0]);
        chk("rx_ready", 32'(bus.rx_ready), 32'(rxq.size() < DEPTH));
        model_edge(c, w, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        step(1'b1, 1'b1, a, d, dummy);
    endtask

    task automatic cpu_rd(input logic [31:0] a, output logic [31:0] rdo);
        step(1'b1, 1'b0, a, 32'h0, rdo);
    endtask

    task automatic idle();
        logic [31:0] dummy;
        step(1'b0, 1'b0, 32'h0, 32'h0, dummy);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        tr = 1'b0;
        rv = 1'b0;
        rdat = 32'h0;
        model_reset();
        bus.cs = 1'b0;
        bus.wr_rd = 1'b0;
        bus.addr = 32'h0;
        bus.data_bus_write = 32'h0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 32'h0;
        rst = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        bus.cs = 1'b1;
        bus.addr = 32'h4;
        #1;
        chk("rst_status", bus.data_bus_read, 32'h0000_0005);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cs = 1'b0;
        @(posedge clk);
        #1;

        // Single TX write becomes visible the next cycle
        cpu_wr(32'h0, 32'hA5A5_0001);
        chk("w1_tx_valid", 32'(bus.tx_valid), 32'h1);
        chk("w1_tx_data", bus.tx_data, 32'hA5A5_0001);
        cpu_rd(32'h4, rd);
        chk("w1_status", rd, 32'h0000_0104);
        cpu_wr(32'h8, 32'h1);
        chk("flush_tx_valid", 32'(bus.tx_valid), 32'h0);

        // Nine writes into an 8-deep TX: overflow, then drain in order
        for (int i = 1; i <= 9; i++) cpu_wr(32'h0, 32'(i));
        cpu_rd(32'h4, rd);
        chk("ovf_full_bit", 32'(rd[1]), 32'h1);
        cpu_rd(32'hC, rd);
        chk("ovf_err", rd, 32'h1);
        cpu_wr(32'hC, 32'h1);
        tr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", bus.tx_data, 32'(i));
            idle();
        end
        chk("drain_empty", 32'(bus.tx_valid), 32'h0);
        tr = 1'b0;

        // Push into full TX while it pops: push dropped, count 7
        for (int i = 0; i < 8; i++) cpu_wr(32'h0, 32'h100 + 32'(i));
        tr = 1'b1;
        cpu_wr(32'h0, 32'hDEAD_BEEF);
        tr = 1'b0;
        cpu_rd(32'h4, rd);
        chk("full_pop_cnt", 32'(rd[11:8]), 32'h7);
        cpu_rd(32'hC, rd);
        chk("full_pop_err", rd, 32'h1);
        cpu_wr(32'hC, 32'h1);
        cpu_rd(32'hC, rd);
        chk("err_w1c", rd, 32'h0);
        cpu_wr(32'h4, 32'hFFFF_FFFF);
        cpu_rd(32'h8, rd);
        chk("ctrl_read_zero", rd, 32'h0);
        cpu_wr(32'h8, 32'h1);

        // RX order and underflow
        rv = 1'b1;
        rdat = 32'h10;
        idle();
        rdat = 32'h20;
        idle();
        rv = 1'b0;
        cpu_rd(32'h0, rd);
        chk("rx_first", rd, 32'h10);
        cpu_rd(32'h0, rd);
        chk("rx_second", rd, 32'h20);
        cpu_rd(32'h0, rd);
        chk("rx_udf_data", rd, 32'h0);
        cpu_rd(32'hC, rd);
        chk("rx_udf_err", rd, 32'h2);
        cpu_rd(32'h4, rd);
        chk("rx_udf_cnt", 32'(rd[19:16]), 32'h0);
        cpu_wr(32'hC, 32'h2);

        // Fill RX, pop one, then the stalled word is captured
        rv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdat = 32'h300 + 32'(i);
            idle();
        end
        chk("rx_full_ready", 32'(bus.rx_ready), 32'h0);
        rdat = 32'h399;
        cpu_rd(32'h0, rd);
        chk("rx_full_pop", rd, 32'h300);
        chk("rx_ready_back", 32'(bus.rx_ready), 32'h1);
        idle();
        rv = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cpu_rd(32'h0, rd);
            chk("rx_drain", rd, 32'h300 + 32'(i));
        end
        cpu_rd(32'h0, rd);
        chk("rx_ninth", rd, 32'h399);

        // Asynchronous reset in mid-cycle with TX holding words
        for (int i = 0; i < 3; i++) cpu_wr(32'h0, 32'h50 + 32'(i));
        bus.cs = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        bus.cs = 1'b1;
        bus.wr_rd = 1'b0;
        bus.addr = 32'h4;
        #1;
        chk("arst_status", bus.data_bus_read, 32'h0000_0005);
        chk("arst_rx_ready", 32'(bus.rx_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cs = 1'b0;
        model_reset();
        cpu_wr(32'h0, 32'h77);
        chk("post_rst_head", bus.tx_data, 32'h77);
        cpu_wr(32'h8, 32'h3);

        // Randomized traffic in three load phases
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 1000; n++) begin
                logic        c;
                logic        w;
                logic [31:0] a;
                logic [31:0] d;
                case (p)
                    0:       begin tr = ($urandom_range(0, 9) < 2); rv = ($urandom_range(0, 9) < 8); end
                    1:       begin tr = ($urandom_range(0, 9) < 8); rv = ($urandom_range(0, 9) < 2); end
                    default: begin tr = ($urandom_range(0, 1) == 1); rv = ($urandom_range(0, 1) == 1); end
                endcase
                rdat = $urandom();
                c = ($urandom_range(0, 9) < 4);
                w = ($urandom_range(0, 1) == 1);
                a = $urandom();
                d = $urandom();
                if (a[3:2] == 2'd2 && $urandom_range(0, 7) != 0) d[1:0] = 2'b00;
                step(c, w, a, d, rd);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
